tdm_demux: RTL and testbench



---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_bit_counter.sv | 37 +++
 rtl/tdm_demux.sv | 165 ++++++++++++++++
 tb/tb_tdm_demux.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the serial channel multiplexer link (mux and demux ends).
package tdm_pkg;

    // Receiver framing state: hunting for a frame-sync marker, or locked and receiving.
    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } tdm_state_t;

    // Number of valid serial bits in one frame.
    function automatic int tdm_frame_len(input int nch, input int w);
        return nch * w;
    endfunction

    // Width of a counter that must represent 0..fl inclusive.
    function automatic int tdm_cnt_width(input int fl);
        return $clog2(fl + 1);
    endfunction

endpackage

// File: rtl/tdm_bit_counter.sv
// Frame bit counter: load-1 for a new frame, clear at frame end, increment per valid bit.
module tdm_bit_counter #(
    parameter int FL = 32,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load1,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          term
);

    logic [CW-1:0] count_reg;

    // Load-1 beats clear beats increment; the FSM never requests load1 and clr together.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load1) begin
            count_reg <= CW'(1);
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Terminal flag: this enabled bit is the one that brings the count to FL.
    always_comb begin
        term = en && (count_reg == CW'(FL - 1));
    end

    assign count = count_reg;

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: recovers NCH words of W bits from a framed serial
// stream and presents each complete frame atomically with a one-cycle valid pulse.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DIN_VALID,
    input  logic             SYNC,
    input  logic             ERR_CLR,
    output logic [NCH*W-1:0] Y,
    output logic             Y_VALID,
    output logic             ERR,
    output logic             LOCKED
);

    localparam int FL = tdm_frame_len(NCH, W);
    localparam int CW = tdm_cnt_width(FL);

    tdm_state_t      state_reg;
    tdm_state_t      state_next;

    // Only the first FL-1 bits need storage; the last bit of a frame is taken
    // straight from DIN on the cycle the frame completes.
    logic [FL-2:0]   shift_reg;
    logic [FL-1:0]   frame_word;
    logic [FL-1:0]   y_next;
    logic [FL-1:0]   y_reg;
    logic            y_valid_reg;
    logic            err_reg;

    logic [CW-1:0]   count;
    logic            cnt_term;
    logic            cnt_load1;
    logic            cnt_clr;
    logic            cnt_en;
    logic            shift_load;
    logic            shift_en;
    logic            y_load;
    logic            err_set;

    tdm_bit_counter #(
        .FL (FL),
        .CW (CW)
    ) u_bit_counter (
        .clk   (CLK),
        .srst  (RST),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .term  (cnt_term)
    );

    // Serial order is channel 0 first, MSB first, so channel 0 ends up in the
    // top word of the shifted frame; reverse word order onto the output bus.
    assign frame_word = {shift_reg, DIN};

    for (genvar gi = 0; gi < NCH; gi++) begin : g_word_map
        assign y_next[gi*W +: W] = frame_word[(NCH-1-gi)*W +: W];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Framing decisions for each valid bit; stalls leave everything untouched.
    always_comb begin
        state_next = state_reg;
        cnt_load1  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        shift_load = 1'b0;
        shift_en   = 1'b0;
        y_load     = 1'b0;
        err_set    = 1'b0;
        if (DIN_VALID) begin
            case (state_reg)
                ST_HUNT: begin
                    if (SYNC) begin
                        cnt_load1  = 1'b1;
                        shift_load = 1'b1;
                        state_next = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (count == '0) begin
                        // Frame boundary: the next frame must open with SYNC.
                        if (SYNC) begin
                            cnt_load1  = 1'b1;
                            shift_load = 1'b1;
                        end else begin
                            err_set    = 1'b1;
                            state_next = ST_HUNT;
                        end
                    end else if (SYNC) begin
                        // Early SYNC: abandon the partial frame and restart on this bit.
                        err_set    = 1'b1;
                        cnt_load1  = 1'b1;
                        shift_load = 1'b1;
                    end else begin
                        cnt_en   = 1'b1;
                        shift_en = 1'b1;
                        if (cnt_term) begin
                            y_load  = 1'b1;
                            cnt_clr = 1'b1;
                        end
                    end
                end
                default: state_next = ST_HUNT;
            endcase
        end
    end

    // Shift register: a new frame starts with this bit as bit 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg <= '0;
        end else if (shift_load) begin
            shift_reg    <= '0;
            shift_reg[0] <= DIN;
        end else if (shift_en) begin
            shift_reg <= frame_word[FL-2:0];
        end
    end

    // Output register and valid pulse: only complete frames reach Y.
    always_ff @(posedge CLK) begin
        if (RST) begin
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            y_valid_reg <= y_load;
            if (y_load) begin
                y_reg <= y_next;
            end
        end
    end

    // Sticky error: a new error in the same cycle as a clear keeps it set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end else if (ERR_CLR) begin
            err_reg <= 1'b0;
        end
    end

    assign Y       = y_reg;
    assign Y_VALID = y_valid_reg;
    assign ERR     = err_reg;
    assign LOCKED  = (state_reg == ST_RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized, self-checking bench for tdm_demux with a frame-level reference model.
module tb_tdm_demux;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int FL  = NCH * W;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          DIN = 1'b0;
    logic          DIN_VALID = 1'b0;
    logic          SYNC = 1'b0;
    logic          ERR_CLR = 1'b0;
    logic [FL-1:0] Y;
    logic          Y_VALID;
    logic          ERR;
    logic          LOCKED;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: lock flag, bits collected since the frame start, outputs.
    bit            m_locked = 1'b0;
    bit            m_bits[$];
    logic [FL-1:0] m_y = '0;
    bit            m_yv = 1'b0;
    bit            m_err = 1'b0;

    tdm_demux #(.NCH(NCH), .W(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .SYNC      (SYNC),
        .ERR_CLR   (ERR_CLR),
        .Y         (Y),
        .Y_VALID   (Y_VALID),
        .ERR       (ERR),
        .LOCKED    (LOCKED)
    );

    always #5 CLK = ~CLK;

    // Apply the framing rules to one sampled input set.
    task automatic model_step(input bit rst, input bit v, input bit d, input bit s, input bit clr);
        bit err_new;
        err_new = 1'b0;
        m_yv    = 1'b0;
        if (rst) begin
            m_locked = 1'b0;
            m_bits.delete();
            m_y   = '0;
            m_err = 1'b0;
            return;
        end
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_bits.delete();
                    m_bits.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (m_bits.size() == 0) begin
                if (s) begin
                    m_bits.push_back(d);
                end else begin
                    err_new  = 1'b1;
                    m_locked = 1'b0;
                end
            end else if (s) begin
                err_new = 1'b1;
                m_bits.delete();
                m_bits.push_back(d);
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == FL) begin
                    for (int i = 0; i < FL; i++) begin
                        m_y[(i / W) * W + (W - 1 - (i % W))] = m_bits[i];
                    end
                    m_yv = 1'b1;
                    m_bits.delete();
                end
            end
        end
        m_err = err_new | (m_err & ~clr);
    endtask

    // One clock cycle of stimulus; the model tracks what the registers should hold after the edge.
    task automatic drive(input bit rst, input bit v, input bit d, input bit s, input bit clr);
        RST       = rst;
        DIN_VALID = v;
        DIN       = d;
        SYNC      = s;
        ERR_CLR   = clr;
        @(posedge CLK);
        model_step(rst, v, d, s, clr);
        #1;
    endtask

    // Serial bit i of a frame whose words are laid out as on Y.
    function automatic logic [FL-1:0] serial_of(input logic [FL-1:0] words);
        logic [FL-1:0] s;
        for (int i = 0; i < FL; i++) begin
            s[i] = words[(i / W) * W + (W - 1 - (i % W))];
        end
        return s;
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rbit(), rbit(), rbit(), rbit());
        end
        n_checks++;
        if (Y !== '0) $display("FAIL reset_y Y=%h expected=%h", Y, {FL{1'b0}});
        else n_pass++;
        n_checks++;
        if (Y_VALID !== 1'b0) $display("FAIL reset_yvalid Y_VALID=%b expected=0", Y_VALID);
        else n_pass++;
        n_checks++;
        if (ERR !== 1'b0) $display("FAIL reset_err ERR=%b expected=0", ERR);
        else n_pass++;
        n_checks++;
        if (LOCKED !== 1'b0) $display("FAIL reset_locked LOCKED=%b expected=0", LOCKED);
        else n_pass++;
        $display("reset: Y=%h Y_VALID=%b ERR=%b LOCKED=%b", Y, Y_VALID, ERR, LOCKED);
    endtask

    task automatic test_clean_frame();
        logic [FL-1:0] fa;
        logic [FL-1:0] fb;
        logic [FL-1:0] sa;
        logic [FL-1:0] sb;
        int pulses;
        int first_pulse;
        int second_pulse;
        fa = 32'h01FF3CA5;
        fb = 32'h44332211;
        sa = serial_of(fa);
        sb = serial_of(fb);
        pulses = 0;
        first_pulse = -1;
        second_pulse = -1;
        for (int i = 0; i < 2 * FL; i++) begin
            drive(1'b0, 1'b1, (i < FL) ? sa[i] : sb[i - FL], (i % FL) == 0, 1'b0);
            n_checks++;
            if ({Y, Y_VALID, ERR, LOCKED} !== {m_y, m_yv, m_err, m_locked})
                $display("FAIL clean_model cyc=%0d Y=%h/%h yv=%b/%b err=%b/%b lock=%b/%b", i, Y, m_y, Y_VALID, m_yv, ERR, m_err, LOCKED, m_locked);
            else n_pass++;
            if (Y_VALID) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                else second_pulse = i;
            end
            if (i == FL - 1) begin
                n_checks++;
                if (Y !== fa || Y_VALID !== 1'b1) $display("FAIL clean_frame_a Y=%h Y_VALID=%b expected Y=%h Y_VALID=1", Y, Y_VALID, fa);
                else n_pass++;
                $display("clean frame A: Y=%h Y_VALID=%b", Y, Y_VALID);
            end
        end
        n_checks++;
        if (Y !== fb) $display("FAIL clean_frame_b Y=%h expected=%h", Y, fb);
        else n_pass++;
        n_checks++;
        if (pulses !== 2 || (second_pulse - first_pulse) !== FL)
            $display("FAIL clean_pulses count=%0d spacing=%0d expected count=2 spacing=%0d", pulses, second_pulse - first_pulse, FL);
        else n_pass++;
        $display("clean frame B: Y=%h pulses=%0d spacing=%0d", Y, pulses, second_pulse - first_pulse);
        drive(1'b0, 1'b0, rbit(), rbit(), 1'b0);
        n_checks++;
        if (Y_VALID !== 1'b0 || Y !== fb) $display("FAIL clean_hold Y=%h Y_VALID=%b expected Y=%h Y_VALID=0", Y, Y_VALID, fb);
        else n_pass++;
    endtask

    task automatic test_stalls();
        logic [FL-1:0] fa;
        logic [FL-1:0] sa;
        fa = 32'h01FF3CA5;
        sa = serial_of(fa);
        for (int i = 0; i < 2 * FL; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b0, rbit(), rbit(), 1'b0);
            else drive(1'b0, 1'b1, sa[i / 2], (i / 2) == 0, 1'b0);
            n_checks++;
            if ({Y, Y_VALID, ERR, LOCKED} !== {m_y, m_yv, m_err, m_locked})
                $display("FAIL stall_model cyc=%0d Y=%h/%h yv=%b/%b err=%b/%b lock=%b/%b", i, Y, m_y, Y_VALID, m_yv, ERR, m_err, LOCKED, m_locked);
            else n_pass++;
        end
        n_checks++;
        if (Y !== fa || Y_VALID !== 1'b1 || ERR !== 1'b0)
            $display("FAIL stall_frame Y=%h Y_VALID=%b ERR=%b expected Y=%h Y_VALID=1 ERR=0", Y, Y_VALID, ERR, fa);
        else n_pass++;
        $display("stalled frame: Y=%h Y_VALID=%b ERR=%b", Y, Y_VALID, ERR);
    endtask

    task automatic test_early_sync();
        logic [FL-1:0] sa;
        logic [FL-1:0] fc;
        logic [FL-1:0] sc;
        sa = serial_of(32'h01FF3CA5);
        fc = FL'($urandom);
        sc = serial_of(fc);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, sa[i], i == 0, 1'b0);
        end
        for (int i = 0; i < FL; i++) begin
            drive(1'b0, 1'b1, sc[i], i == 0, 1'b0);
            n_checks++;
            if ({Y, Y_VALID, ERR, LOCKED} !== {m_y, m_yv, m_err, m_locked})
                $display("FAIL early_model cyc=%0d Y=%h/%h yv=%b/%b err=%b/%b lock=%b/%b", i, Y, m_y, Y_VALID, m_yv, ERR, m_err, LOCKED, m_locked);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (ERR !== 1'b1 || Y !== '0 || LOCKED !== 1'b1)
                    $display("FAIL early_sync ERR=%b Y=%h LOCKED=%b expected ERR=1 Y=0 LOCKED=1", ERR, Y, LOCKED);
                else n_pass++;
            end
        end
        n_checks++;
        if (Y !== fc || Y_VALID !== 1'b1) $display("FAIL early_restart Y=%h Y_VALID=%b expected Y=%h Y_VALID=1", Y, Y_VALID, fc);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ERR !== 1'b0) $display("FAIL early_err_clr ERR=%b expected=0", ERR);
        else n_pass++;
        $display("early sync: restarted Y=%h ERR after clear=%b", Y, ERR);
    endtask

    task automatic test_hunt_missing_sync();
        logic [FL-1:0] fd;
        logic [FL-1:0] sd;
        fd = FL'($urandom);
        sd = serial_of(fd);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, rbit(), 1'b0, 1'b0);
            n_checks++;
            if (LOCKED !== 1'b0 || Y_VALID !== 1'b0 || ERR !== 1'b0)
                $display("FAIL hunt_discard bit=%0d LOCKED=%b Y_VALID=%b ERR=%b expected all 0", i, LOCKED, Y_VALID, ERR);
            else n_pass++;
        end
        for (int i = 0; i < FL; i++) begin
            drive(1'b0, 1'b1, sd[i], i == 0, 1'b0);
        end
        n_checks++;
        if (Y !== fd || LOCKED !== 1'b1) $display("FAIL hunt_frame Y=%h LOCKED=%b expected Y=%h LOCKED=1", Y, LOCKED, fd);
        else n_pass++;
        drive(1'b0, 1'b1, rbit(), 1'b0, 1'b0);
        n_checks++;
        if (ERR !== 1'b1 || LOCKED !== 1'b0 || Y !== fd)
            $display("FAIL missing_sync ERR=%b LOCKED=%b Y=%h expected ERR=1 LOCKED=0 Y=%h", ERR, LOCKED, Y, fd);
        else n_pass++;
        $display("missing sync: ERR=%b LOCKED=%b Y=%h", ERR, LOCKED, Y);
    endtask

    task automatic test_reset_mid_frame();
        logic [FL-1:0] sa;
        logic [FL-1:0] fe;
        logic [FL-1:0] se;
        logic [FL-1:0] ff;
        logic [FL-1:0] sf;
        sa = serial_of(32'h01FF3CA5);
        fe = FL'($urandom);
        se = serial_of(fe);
        ff = FL'($urandom);
        sf = serial_of(ff);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < FL; i++) drive(1'b0, 1'b1, sa[i], i == 0, 1'b0);
        n_checks++;
        if (Y !== 32'h01FF3CA5) $display("FAIL rstmid_prev Y=%h expected=01ff3ca5", Y);
        else n_pass++;
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, se[i], i == 0, 1'b0);
        drive(1'b1, 1'b1, se[20], 1'b0, 1'b0);
        n_checks++;
        if (Y !== '0 || LOCKED !== 1'b0 || Y_VALID !== 1'b0)
            $display("FAIL rstmid_clear Y=%h LOCKED=%b Y_VALID=%b expected all 0", Y, LOCKED, Y_VALID);
        else n_pass++;
        for (int i = 0; i < FL; i++) drive(1'b0, 1'b1, sf[i], i == 0, 1'b0);
        n_checks++;
        if (Y !== ff || Y_VALID !== 1'b1) $display("FAIL rstmid_next Y=%h Y_VALID=%b expected Y=%h Y_VALID=1", Y, Y_VALID, ff);
        else n_pass++;
        $display("reset mid-frame: following frame Y=%h", Y);
    endtask

    task automatic test_random();
        int pos;
        int errs_before;
        bit v;
        bit s;
        bit r;
        pos = 0;
        errs_before = n_checks - n_pass;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            v = ($urandom_range(0, 3) != 0);
            if (pos % FL == 0) s = ($urandom_range(0, 15) != 0);
            else s = ($urandom_range(0, 99) == 0);
            drive(r, v, rbit(), s, $urandom_range(0, 49) == 0);
            if (r) pos = 0;
            else if (v) pos = s ? 1 : pos + 1;
            n_checks++;
            if ({Y, Y_VALID, ERR, LOCKED} !== {m_y, m_yv, m_err, m_locked})
                $display("FAIL random_model cyc=%0d Y=%h/%h yv=%b/%b err=%b/%b lock=%b/%b", i, Y, m_y, Y_VALID, m_yv, ERR, m_err, LOCKED, m_locked);
            else n_pass++;
        end
        $display("random stream: 3000 cycles, new discrepancies=%0d", (n_checks - n_pass) - errs_before);
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_stalls();
        test_early_sync();
        test_hunt_missing_sync();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
